demux_1x2_stream_router: RTL and testbench
==========================================

Name: demux_1x2_stream_router

Overview:
- Packet-level controller for the 1x2 demux datapath: accepts one valid/ready input stream and steers whole packets to output port 0 or port 1.
- The port is chosen per packet, either from a sideband destination bit or by round-robin alternation.
- Each output port has a one-entry register slice, so every output is registered.
- Sits between a single packet source and two downstream consumers that share it.

Parameters:
- DATA_W, 8, width of the data beat.
- CNT_W, 16, width of each per-port packet counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_rr  in  1  1 = round-robin port choice, 0 = use s_dest. Sampled only at the start of a packet.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  DATA_W  input beat data.
- s_last  in  1  last beat of the packet.
- s_dest  in  1  destination port. Sampled on the first beat only.
- m0_valid / m1_valid  out  1  output beat valid.
- m0_ready / m1_ready  in  1  downstream ready.
- m0_data / m1_data  out  DATA_W  output data.
- m0_last / m1_last  out  1  output last flag.
- busy  out  1  high while a packet is in progress (state BUSY).
- pkt_cnt0 / pkt_cnt1  out  CNT_W  completed packets per port; saturate at all-ones.

Behaviour:
- Reset values (rst=1 at a clock edge): state=IDLE, rr_ptr=0, cur_port=0, both slices empty, m*_valid=0, m*_data=0, m*_last=0, busy=0, pkt_cnt*=0.
- Reset mid-packet discards the in-flight packet and any buffered beats; no partial-packet flush.
- Target port:
  - In IDLE: tgt = cfg_rr ? rr_ptr : s_dest.
  - In BUSY: tgt = cur_port.
- s_ready = !mX_valid || mX_ready, where X = tgt. The port that is not the target never back-pressures the input. s_ready does not depend on s_valid.
- Accept = s_valid && s_ready. On accept, slice X loads {s_data, s_last} and mX_valid=1 next cycle. Latency input→output is 1 cycle.
- A slice whose beat is taken (mX_valid && mX_ready) without a new load clears mX_valid. A simultaneous drain and load keeps it valid with the new beat, giving full throughput of 1 beat/cycle.
- FSM, IDLE → BUSY: accept with s_last=0; cur_port ← tgt.
- FSM, IDLE → IDLE: accept with s_last=1 (single-beat packet). The packet completes that cycle.
- FSM, BUSY → IDLE: accept with s_last=1. The packet completes.
- FSM, BUSY → BUSY: otherwise. s_dest and cfg_rr are ignored while BUSY.
- On packet completion to port X:
  - pkt_cnt X increments unless it is already all-ones (saturation).
  - If cfg_rr was 1 when the packet started, rr_ptr ← ~X. Otherwise rr_ptr is unchanged.
- The packet-start cfg_rr value is registered together with cur_port.
- Both ports may drain in the same cycle. A beat for the new port may be accepted while the previous port's slice is still full.
- Packets are never interleaved or reordered; all beats of a packet go to one port.
- busy = (state == BUSY).
- s_valid must stay asserted with stable s_data, s_last and s_dest until accepted. This is the upstream contract; the bench asserts it.

Decomposition:
- Package demux_router_pkg:
  - state enum {IDLE, BUSY}.
  - localparam PORT0 = 1'b0, PORT1 = 1'b1.
- One sub-module: stream_reg_slice (one-entry valid/ready register for data+last), instantiated twice.
- FSM, port selection, rr_ptr and counters stay in the top module.

Test Plan:
- Reset → all outputs 0, busy=0, s_ready=1 with both ports empty.
- Explicit routing: cfg_rr=0, 3-beat packet 0x11,0x22,0x33(last) with s_dest=1, m1_ready=1 → m1 emits the same beats 1 cycle after each accept, m1_last on 0x33, m0_valid stays 0, pkt_cnt1=1.
- s_dest changed mid-packet: cfg_rr=0, first beat s_dest=0, then s_dest=1 on beats 2–3 → all 3 beats appear on m0; pkt_cnt0=1.
- Round-robin: cfg_rr=1, four 1-beat packets 0xA0..0xA3 back-to-back, both readies=1 → ports 0,1,0,1; s_ready high every cycle; pkt_cnt0=pkt_cnt1=2.
- Back-pressure isolation: m0_ready=0 with slice 0 full, next packet targeted to port 1 → s_ready=1 and the packet delivered on m1. Then a packet to port 0 → s_ready=0 until m0_ready=1.
- Reset mid-packet: rst for 1 cycle after beat 2 of a 4-beat packet → busy=0, m*_valid=0 next cycle, rr_ptr=0, counters 0. A new packet then routes normally.
- Saturation: preload-by-stimulus with CNT_W=2 override, 5 packets to port 0 → pkt_cnt0 stops at 3.

Source files
------------

// File: rtl/demux_1x2_stream_router_pkg.sv
// Shared types and constants for the 1x2 packet demux router.
package demux_router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/demux_1x2_stream_router_slice.sv
// One-entry valid/ready register slice holding a data beat and its last flag.
module stream_reg_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  // A load wins over a drain so a beat taken this cycle is replaced in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/demux_1x2_stream_router.sv
// Packet-level 1x2 stream router: steers whole packets to port 0 or 1 by sideband bit or round-robin.
module demux_1x2_stream_router
  import demux_router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_rr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_dest,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  state_t           r_state;
  logic             r_rr_ptr;
  logic             r_cur_port;
  logic             r_cur_rr;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_tgt;
  logic w_rr_mode;
  logic w_accept;
  logic w_done;
  logic w_load0;
  logic w_load1;

  assign w_tgt     = (r_state == IDLE) ? (cfg_rr ? r_rr_ptr : s_dest) : r_cur_port;
  assign w_rr_mode = (r_state == IDLE) ? cfg_rr : r_cur_rr;
  // Only the target slice can back-pressure the source.
  assign s_ready   = (w_tgt == PORT1) ? (!m1_valid || m1_ready) : (!m0_valid || m0_ready);
  assign w_accept  = s_valid && s_ready;
  assign w_done    = w_accept && s_last;
  assign w_load0   = w_accept && (w_tgt == PORT0);
  assign w_load1   = w_accept && (w_tgt == PORT1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_cur_port <= PORT0;
      r_cur_rr   <= 1'b0;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
    end else begin
      if (w_accept) begin
        case (r_state)
          IDLE: begin
            if (!s_last) begin
              r_state    <= BUSY;
              r_cur_port <= w_tgt;
              r_cur_rr   <= cfg_rr;
            end
          end
          BUSY: begin
            if (s_last) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
      if (w_done) begin
        if (w_tgt == PORT0) begin
          if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
        end else begin
          if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
        if (w_rr_mode) r_rr_ptr <= ~w_tgt;
      end
    end
  end

  assign busy     = (r_state == BUSY);
  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;

  stream_reg_slice #(.DATA_W(DATA_W)) u_slice0 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load0),
    .i_data  (s_data),
    .i_last  (s_last),
    .i_ready (m0_ready),
    .o_valid (m0_valid),
    .o_data  (m0_data),
    .o_last  (m0_last)
  );

  stream_reg_slice #(.DATA_W(DATA_W)) u_slice1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load1),
    .i_data  (s_data),
    .i_last  (s_last),
    .i_ready (m1_ready),
    .o_valid (m1_valid),
    .o_data  (m1_data),
    .o_last  (m1_last)
  );

endmodule

// File: tb/tb_demux_1x2_stream_router.sv
// Directed scoreboard bench for demux_1x2_stream_router (counters narrowed to 2 bits).
module tb_demux_1x2_stream_router;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic              cfg_rr;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_dest;
  logic              m0_valid, m1_valid;
  logic              m0_ready, m1_ready;
  logic [DATA_W-1:0] m0_data, m1_data;
  logic              m0_last, m1_last;
  logic              busy;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  demux_1x2_stream_router #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_rr   (cfg_rr),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_dest   (s_dest),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_data  (m0_data),
    .m0_last  (m0_last),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_data  (m1_data),
    .m1_last  (m1_last),
    .busy     (busy),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every beat leaving a port must match the head of that port's queue.
  logic              p_valid, p_ready, p_last, p_dest;
  logic [DATA_W-1:0] p_data;
  initial begin
    p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0; p_dest = 1'b0; p_data = '0;
  end
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (m0_valid && m0_ready) begin
        chk("m0_beat_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("m0_data", 32'(m0_data), 32'(e[7:0]));
          chk("m0_last", 32'(m0_last), 32'(e[8]));
        end
      end
      if (m1_valid && m1_ready) begin
        chk("m1_beat_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("m1_data", 32'(m1_data), 32'(e[7:0]));
          chk("m1_last", 32'(m1_last), 32'(e[8]));
        end
      end
      if (p_valid && !p_ready)
        chk("upstream_hold", 32'({s_valid, s_data, s_last, s_dest}),
            32'({1'b1, p_data, p_last, p_dest}));
    end
    p_valid = s_valid; p_ready = s_ready; p_data = s_data; p_last = s_last; p_dest = s_dest;
  end

  // Presents one beat and holds it until accepted; s_valid stays high on return.
  task automatic send(input logic [7:0] d, input logic l, input logic dst, input logic port,
                      output int waits);
    bit ok;
    s_valid = 1'b1; s_data = d; s_last = l; s_dest = dst;
    ok = 1'b0;
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    chk("accept_in_time", 32'(ok), 32'd1);
    if (ok) begin
      if (port) q1.push_back({l, d});
      else      q0.push_back({l, d});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int w;
    rst = 1'b1; cfg_rr = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_dest = 1'b0;
    m0_ready = 1'b0; m1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_outputs", 32'({m0_valid, m0_data, m0_last, m1_valid, m1_data, m1_last, busy}), 32'd0);
    chk("rst_counters", 32'({pkt_cnt0, pkt_cnt1}), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Explicit routing to port 1, one-cycle latency
    cfg_rr = 1'b0; m1_ready = 1'b1; m0_ready = 1'b1;
    send(8'h11, 1'b0, 1'b1, 1'b1, w);
    chk("exp_lat_v1", 32'({m1_valid, m1_data, m1_last}), 32'({1'b1, 8'h11, 1'b0}));
    chk("exp_busy", 32'(busy), 32'd1);
    send(8'h22, 1'b0, 1'b1, 1'b1, w);
    chk("exp_lat_v2", 32'({m1_valid, m1_data, m1_last}), 32'({1'b1, 8'h22, 1'b0}));
    send(8'h33, 1'b1, 1'b1, 1'b1, w);
    s_valid = 1'b0;
    chk("exp_lat_v3", 32'({m1_valid, m1_data, m1_last}), 32'({1'b1, 8'h33, 1'b1}));
    chk("exp_m0_quiet", 32'(m0_valid), 32'd0);
    chk("exp_idle", 32'(busy), 32'd0);
    chk("exp_cnt", 32'({pkt_cnt0, pkt_cnt1}), 32'({2'd0, 2'd1}));
    idle(2);

    // s_dest ignored after the first beat
    do_reset();
    send(8'h44, 1'b0, 1'b0, 1'b0, w);
    send(8'h55, 1'b0, 1'b1, 1'b0, w);
    send(8'h66, 1'b1, 1'b1, 1'b0, w);
    idle(2);
    chk("dest_mid_cnt", 32'({pkt_cnt0, pkt_cnt1}), 32'({2'd1, 2'd0}));

    // Round-robin, back-to-back single-beat packets, s_dest set to the wrong port
    do_reset();
    cfg_rr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), 1'b1, ~1'(i), 1'(i), w);
      chk("rr_no_stall", 32'(w), 32'd0);
    end
    idle(2);
    chk("rr_cnt", 32'({pkt_cnt0, pkt_cnt1}), 32'({2'd2, 2'd2}));

    // Back-pressure isolation
    do_reset();
    cfg_rr = 1'b0; m0_ready = 1'b0; m1_ready = 1'b1;
    send(8'hB0, 1'b1, 1'b0, 1'b0, w);
    send(8'hB1, 1'b1, 1'b1, 1'b1, w);
    chk("bp_other_port_free", 32'(w), 32'd0);
    chk("bp_m1_out", 32'({m1_valid, m1_data}), 32'({1'b1, 8'hB1}));
    s_valid = 1'b1; s_data = 8'hB2; s_last = 1'b1; s_dest = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stalled", 32'(s_ready), 32'd0);
    end
    @(posedge clk); #1;
    m0_ready = 1'b1;
    send(8'hB2, 1'b1, 1'b0, 1'b0, w);
    chk("bp_released", 32'(w), 32'd0);
    idle(2);
    chk("bp_cnt", 32'({pkt_cnt0, pkt_cnt1}), 32'({2'd2, 2'd1}));

    // Reset mid-packet: first move rr_ptr to 1, then abort a 4-beat packet
    do_reset();
    cfg_rr = 1'b1;
    send(8'hC0, 1'b1, 1'b1, 1'b0, w);
    cfg_rr = 1'b0;
    send(8'hC1, 1'b0, 1'b1, 1'b1, w);
    send(8'hC2, 1'b0, 1'b1, 1'b1, w);
    do_reset();
    chk("mid_rst_state", 32'({busy, m0_valid, m1_valid}), 32'd0);
    chk("mid_rst_cnt", 32'({pkt_cnt0, pkt_cnt1}), 32'd0);
    cfg_rr = 1'b1;
    send(8'hC3, 1'b1, 1'b1, 1'b0, w);
    s_valid = 1'b0;
    chk("mid_rst_rr_ptr0", 32'({m0_valid, m0_data, m1_valid}), 32'({1'b1, 8'hC3, 1'b0}));
    idle(2);

    // Saturation of the 2-bit counter
    do_reset();
    cfg_rr = 1'b0;
    for (int i = 0; i < 5; i++) send(8'hD0 + 8'(i), 1'b1, 1'b0, 1'b0, w);
    idle(2);
    chk("sat_cnt0", 32'(pkt_cnt0), 32'd3);
    chk("sat_cnt1", 32'(pkt_cnt1), 32'd0);

    // Everything pushed must have come out
    idle(4);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
